// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: FSM encoding,
// 100 MHz board timing defaults and the event-bit index names.
package btn_pkg;

  typedef enum logic [1:0] {
    REL = 2'd0,
    PRS = 2'd1,
    HLD = 2'd2
  } btn_state_e;

  localparam int DEF_N_BTN           = 4;
  localparam int DEF_CNT_W           = 26;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;   // 10 ms
  localparam int DEF_HOLD_CYCLES     = 50_000_000;  // 0.5 s
  localparam int DEF_REPEAT_CYCLES   = 10_000_000;  // 0.1 s

  localparam int BTN_RST   = 0;
  localparam int BTN_INPUT = 1;
  localparam int BTN_ENTER = 2;
  localparam int BTN_CDOWN = 3;

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bundle between the board pins / timer FSM and the conditioner.
// slave = conditioner side, master = pins and event consumer side.
interface btn_conditioner_if #(
  parameter int N_BTN = 4
) ();

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] repeat_en;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_long;

  modport slave (
    input  btn_raw,
    input  repeat_en,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_long
  );

  modport master (
    output btn_raw,
    output repeat_en,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_long
  );

endinterface

// File: rtl/btn_channel.sv
// One button: 2-flop sync, counter debounce, REL/PRS/HLD event FSM.
// Press/release 2+DEBOUNCE_CYCLES edges after raw change; no backpressure.
module btn_channel
  import btn_pkg::*;
#(
  parameter int CNT_W           = DEF_CNT_W,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  if (CNT_W < 1 || CNT_W > 31) begin : g_bad_cnt_w
    $error("btn_channel: CNT_W out of range");
  end
  if (DEBOUNCE_CYCLES < 1 || longint'(DEBOUNCE_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_db
    $error("btn_channel: DEBOUNCE_CYCLES does not fit CNT_W");
  end
  if (HOLD_CYCLES < 1 || longint'(HOLD_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_hold
    $error("btn_channel: HOLD_CYCLES does not fit CNT_W");
  end
  if (REPEAT_CYCLES < 1 || longint'(REPEAT_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_rep
    $error("btn_channel: REPEAT_CYCLES does not fit CNT_W");
  end

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             sync_meta;
  logic             sync;
  logic [CNT_W-1:0] db_cnt;
  logic             mismatch;
  logic             db_done;
  logic             rise;
  logic             fall;

  btn_state_e       state_q;
  btn_state_e       state_d;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_cnt_d;
  logic [CNT_W-1:0] rep_cnt;
  logic [CNT_W-1:0] rep_cnt_d;
  logic             hold_done;
  logic             rep_done;
  logic             press_d;
  logic             release_d;
  logic             long_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= btn_raw;
      sync      <= sync_meta;
    end
  end

  // Any cycle of agreement restarts the count, so bounces never accumulate.
  assign mismatch = sync ^ btn_level;
  assign db_done  = mismatch && (db_cnt == DB_LAST);
  assign rise     = db_done && !btn_level;
  assign fall     = db_done &&  btn_level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt    <= '0;
      btn_level <= 1'b0;
    end else begin
      if (!mismatch || db_done) db_cnt <= '0;
      else                      db_cnt <= db_cnt + CNT_ONE;
      if (db_done) btn_level <= ~btn_level;
    end
  end

  assign hold_done = (state_q == PRS) && (hold_cnt == HOLD_LAST);
  assign rep_done  = (state_q == HLD) && (rep_cnt == REP_LAST);

  // State, counters and event pulses all register on the same edge as the
  // level change, so press/release line up with btn_level exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= REL;
      hold_cnt    <= '0;
      rep_cnt     <= '0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_long    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt    <= hold_cnt_d;
      rep_cnt     <= rep_cnt_d;
      btn_press   <= press_d;
      btn_release <= release_d;
      btn_long    <= long_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      REL:     if (rise) state_d = PRS;
      PRS: begin
        if (fall)           state_d = REL;
        else if (hold_done) state_d = HLD;
      end
      HLD:     if (fall) state_d = REL;
      default: state_d = REL;
    endcase
  end

  // A release wins over a same-cycle hold or repeat expiry.
  always_comb begin
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    hold_cnt_d = '0;
    rep_cnt_d  = '0;
    case (state_q)
      REL: press_d = rise;
      PRS: begin
        if (fall) begin
          release_d = 1'b1;
        end else if (hold_done) begin
          long_d  = 1'b1;
          press_d = repeat_en;
        end else begin
          hold_cnt_d = hold_cnt + CNT_ONE;
        end
      end
      HLD: begin
        if (fall) begin
          release_d = 1'b1;
        end else if (rep_done) begin
          press_d = repeat_en;
        end else begin
          rep_cnt_d = rep_cnt + CNT_ONE;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/btn_conditioner.sv
// Conditions N_BTN independent push-buttons into level and 1-cycle events.
// Latency 2+DEBOUNCE_CYCLES cycles raw-to-event; no backpressure, events are pulses.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = DEF_N_BTN,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input logic              clk,
  input logic              rst,
  btn_conditioner_if.slave bus
);

  logic [N_BTN-1:0] level_v;
  logic [N_BTN-1:0] press_v;
  logic [N_BTN-1:0] release_v;
  logic [N_BTN-1:0] long_v;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .CNT_W           (CNT_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .btn_raw     (bus.btn_raw[i]),
      .repeat_en   (bus.repeat_en[i]),
      .btn_level   (level_v[i]),
      .btn_press   (press_v[i]),
      .btn_release (release_v[i]),
      .btn_long    (long_v[i])
    );
  end

  assign bus.btn_level   = level_v;
  assign bus.btn_press   = press_v;
  assign bus.btn_release = release_v;
  assign bus.btn_long    = long_v;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short timing (DB=4, HOLD=10, REP=3).
module tb_btn_conditioner;
  import btn_pkg::*;

  localparam int N        = 4;
  localparam int EV_PRESS = 0;
  localparam int EV_REL   = 1;
  localparam int EV_LONG  = 2;

  typedef struct {
    int t;
    int ch;
    int kind;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_miss = 0;
  ev_t  ev_log[$];

  btn_conditioner_if #(.N_BTN(N)) bus ();

  btn_conditioner #(
    .N_BTN           (N),
    .CNT_W           (8),
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (10),
    .REPEAT_CYCLES   (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event log stamped with the cycle count of the edge that raised the pulse.
  always @(negedge clk) begin
    for (int c = 0; c < N; c++) begin
      if (bus.btn_press[c])   ev_log.push_back('{t: cyc, ch: c, kind: EV_PRESS});
      if (bus.btn_release[c]) ev_log.push_back('{t: cyc, ch: c, kind: EV_REL});
      if (bus.btn_long[c])    ev_log.push_back('{t: cyc, ch: c, kind: EV_LONG});
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int n_ev(input int kind, input int ch);
    int n = 0;
    foreach (ev_log[i]) if (ev_log[i].kind == kind && ev_log[i].ch == ch) n++;
    return n;
  endfunction

  function automatic int t_ev(input int kind, input int ch, input int idx);
    int n = 0;
    foreach (ev_log[i]) begin
      if (ev_log[i].kind == kind && ev_log[i].ch == ch) begin
        if (n == idx) return ev_log[i].t;
        n++;
      end
    end
    return -1;
  endfunction

  // k = cycle index of the first edge that samples the new raw value.
  task automatic raw_set(input int ch, input logic v, output int k);
    @(negedge clk);
    bus.btn_raw[ch] = v;
    k = cyc + 1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold_test(input logic rep, input string pfx);
    int k, t0;
    int offs[8] = '{0, 10, 13, 16, 19, 22, 25, 28};
    ev_log.delete();
    bus.repeat_en[2] = rep;
    raw_set(2, 1'b1, k);
    t0 = k + 5;
    repeat (30) @(negedge clk);
    bus.btn_raw[2] = 1'b0;
    repeat (12) @(negedge clk);
    if (rep) begin
      chk({pfx, "_n_press"}, n_ev(EV_PRESS, 2), 8);
      for (int i = 0; i < 8; i++)
        chk($sformatf("%s_t_press%0d", pfx, i), t_ev(EV_PRESS, 2, i), t0 + offs[i]);
    end else begin
      chk({pfx, "_n_press"}, n_ev(EV_PRESS, 2), 1);
      chk({pfx, "_t_press"}, t_ev(EV_PRESS, 2, 0), t0);
    end
    chk({pfx, "_n_long"}, n_ev(EV_LONG, 2), 1);
    chk({pfx, "_t_long"}, t_ev(EV_LONG, 2, 0), t0 + 10);
    chk({pfx, "_n_rel"}, n_ev(EV_REL, 2), 1);
    chk({pfx, "_t_rel"}, t_ev(EV_REL, 2, 0), t0 + 30);
    bus.repeat_en[2] = 1'b1;
  endtask

  initial begin
    int k, k2;
    rst           = 1'b1;
    bus.btn_raw   = '0;
    bus.repeat_en = '1;
    #2;
    chk("rst_level", int'(bus.btn_level), 0);
    chk("rst_press", int'(bus.btn_press), 0);
    chk("rst_rel",   int'(bus.btn_release), 0);
    chk("rst_long",  int'(bus.btn_long), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Clean press on channel 1, short enough that no long-press fires.
    ev_log.delete();
    raw_set(1, 1'b1, k);
    wait_cyc(5);
    chk("t1_press_early", int'(bus.btn_press[1]), 0);
    wait_cyc(1);
    chk("t1_press", int'(bus.btn_press[1]), 1);
    chk("t1_level", int'(bus.btn_level[1]), 1);
    wait_cyc(2);
    raw_set(1, 1'b0, k2);
    wait_cyc(12);
    chk("t1_n_press", n_ev(EV_PRESS, 1), 1);
    chk("t1_t_press", t_ev(EV_PRESS, 1, 0), k + 5);
    chk("t1_n_long",  n_ev(EV_LONG, 1), 0);
    chk("t1_n_rel",   n_ev(EV_REL, 1), 1);
    chk("t1_t_rel",   t_ev(EV_REL, 1, 0), k2 + 5);

    // Bounce: 2-cycle toggles, last one sticks high.
    ev_log.delete();
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bus.btn_raw[0] = (i % 2 == 0);
      if (i == 4) k = cyc + 1;
      repeat (2) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("t2_n_press", n_ev(EV_PRESS, 0), 1);
    chk("t2_t_press", t_ev(EV_PRESS, 0, 0), k + 5);
    raw_set(0, 1'b0, k2);
    repeat (10) @(negedge clk);

    // Glitch shorter than the debounce window.
    ev_log.delete();
    raw_set(0, 1'b1, k);
    repeat (3) @(negedge clk);
    bus.btn_raw[0] = 1'b0;
    repeat (12) @(negedge clk);
    chk("t2_glitch_events", ev_log.size(), 0);
    chk("t2_glitch_level",  int'(bus.btn_level), 0);

    hold_test(1'b1, "t3");
    hold_test(1'b0, "t4");

    // Reset while in HLD, button still held through deassertion.
    ev_log.delete();
    raw_set(3, 1'b1, k);
    repeat (16) @(posedge clk);
    #2;
    chk("t5_long_pre", int'(bus.btn_long[3]), 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_level", int'(bus.btn_level), 0);
    chk("t5_rst_press", int'(bus.btn_press), 0);
    chk("t5_rst_long",  int'(bus.btn_long), 0);
    chk("t5_rst_rel",   int'(bus.btn_release), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    k = cyc + 1;
    wait_cyc(5);
    chk("t5_repress_early", int'(bus.btn_press[3]), 0);
    wait_cyc(1);
    chk("t5_repress", int'(bus.btn_press[3]), 1);
    chk("t5_n_rel",   n_ev(EV_REL, 3), 0);
    raw_set(3, 1'b0, k2);
    repeat (12) @(negedge clk);

    // Channels 0 and 2 together.
    ev_log.delete();
    @(negedge clk);
    bus.btn_raw[0] = 1'b1;
    bus.btn_raw[2] = 1'b1;
    k = cyc + 1;
    wait_cyc(5);
    chk("t6_press_early", int'(bus.btn_press), 0);
    wait_cyc(1);
    chk("t6_press", int'(bus.btn_press), 4'b0101);
    chk("t6_level", int'(bus.btn_level), 4'b0101);
    @(negedge clk);
    bus.btn_raw[0] = 1'b0;
    bus.btn_raw[2] = 1'b0;
    k2 = cyc + 1;
    repeat (10) @(negedge clk);
    chk("t6_n_press1", n_ev(EV_PRESS, 1), 0);
    chk("t6_n_press3", n_ev(EV_PRESS, 3), 0);
    chk("t6_t_rel0",   t_ev(EV_REL, 0, 0), k2 + 5);
    chk("t6_t_rel2",   t_ev(EV_REL, 2, 0), k2 + 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
